// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson (twisted-ring) sequence controller.
//
// Contents:
//   state_e        controller states IDLE / RUN / HALT
//   OP_*           command opcodes carried on cmd_op
//   MAXW           widest ring the helper functions support
//   johnson_next   ring value after one advance
//   johnson_phase  sequence index 0..2w-1 of a ring value
//   johnson_valid  1 when a value is a member of the rotation sequence
//
// The helper functions take the ring width as an argument. Ring values are
// zero-extended to MAXW bits so one function body serves every WIDTH.
package johnson_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  // Shift right by one; the inverted last stage feeds the first stage (bit w-1).
  function automatic logic [MAXW-1:0] johnson_next(input int w, input logic [MAXW-1:0] r);
    logic [MAXW-1:0] n;
    n = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i == w - 1) n[i] = ~r[0];
      else if (i < w - 1) n[i] = r[i+1];
    end
    return n;
  endfunction

  // Filling half of the sequence has bit 0 clear, so the index is the number
  // of ones; the draining half has bit 0 set and counts down from 2w.
  function automatic int johnson_phase(input int w, input logic [MAXW-1:0] r);
    int pc;
    pc = 0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) pc += int'(r[i]);
    end
    return r[0] ? (2 * w - pc) : pc;
  endfunction

  // Legal codes have their ones packed against the MSB or against the LSB
  // (all-zero and all-one satisfy both).
  function automatic logic johnson_valid(input int w, input logic [MAXW-1:0] r);
    int pc;
    logic [MAXW-1:0] hi;
    logic [MAXW-1:0] lo;
    pc = 0;
    hi = '0;
    lo = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) pc += int'(r[i]);
    end
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) begin
        hi[i] = (i >= w - pc);
        lo[i] = (i < pc);
      end
    end
    return (r == hi) || (r == lo);
  endfunction

endpackage

// File: rtl/johnson_ring.sv
// Johnson ring register.
//
// Ports:
//   clk        rising-edge clock
//   clear      synchronous active-high reset, ring returns to all-zero
//   adv        advance the ring one position this cycle
//   load       replace the ring with load_data (wins over adv)
//   load_data  value written on load
//   ring       current ring state, bit WIDTH-1 is the first stage
//   wrap       this cycle's advance takes 0...01 back to all-zero
module johnson_ring
  import johnson_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] ring,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    if (clear) begin
      ring <= '0;
    end else if (load) begin
      ring <= load_data;
    end else if (adv) begin
      ring <= WIDTH'(johnson_next(WIDTH, MAXW'(ring)));
    end
  end

  // A load replaces the advance, so it can never complete a rotation.
  assign wrap = adv & ~load & (ring == WIDTH'(1));

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequence controller for a WIDTH-stage Johnson counter.
//
// Ports:
//   clk         rising-edge clock
//   clear       synchronous active-high reset, overrides every other input
//   cmd_valid   command offered
//   cmd_ready   command accepted when cmd_valid & cmd_ready
//   cmd_op      OP_NOP / OP_RUN / OP_STEP / OP_STOP
//   cmd_cycles  rotation target for RUN, 0 means free-run
//   ring        Johnson state, bit WIDTH-1 is the first stage
//   phase       sequence index 0..2*WIDTH-1 of ring (combinational)
//   cycle_cnt   completed wraps since the last accepted RUN
//   busy        controller is not IDLE
//   done        one-cycle pulse on the first IDLE cycle after a run ends
//   dbg_state   current controller state (state_e encoding)
//   load_valid, load_data, illegal   only with JOHNSON_LOAD_EN defined:
//               direct ring load in IDLE; illegal is sticky on a bad code.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on the state (high in IDLE
// and RUN, low in HALT) and never on cmd_valid.
//
// Build option: JOHNSON_LOAD_EN adds the load port and the illegal flag.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CYC_W = 8,
  parameter int PH_W  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CYC_W-1:0] cmd_cycles,
`ifdef JOHNSON_LOAD_EN
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             illegal,
`endif
  output logic [WIDTH-1:0] ring,
  output logic [PH_W-1:0]  phase,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  state_e           state;
  logic [CYC_W-1:0] target;
  logic             cmd_fire;
  logic             stop_fire;
  logic             step_fire;
  logic             adv;
  logic             wrap;
  logic             load_fire;
  logic [WIDTH-1:0] load_value;
  logic             target_hit;

`ifdef JOHNSON_LOAD_EN
  logic load_ok;
  assign load_ok    = johnson_valid(WIDTH, MAXW'(load_data));
  assign load_fire  = load_valid & (state == IDLE);
  assign load_value = load_ok ? load_data : '0;
`else
  assign load_fire  = 1'b0;
  assign load_value = '0;
`endif

  assign cmd_ready = (state == IDLE) | (state == RUN);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign stop_fire = cmd_fire & (cmd_op == OP_STOP);
  // A simultaneous load swallows the step; the command is still consumed.
  assign step_fire = cmd_fire & (state == IDLE) & (cmd_op == OP_STEP) & ~load_fire;
  assign adv       = (state != IDLE) | step_fire;

  assign target_hit = (target != '0) & wrap & (CYC_W'(cycle_cnt + 1'b1) == target);

  johnson_ring #(.WIDTH(WIDTH)) u_ring (
    .clk       (clk),
    .clear     (clear),
    .adv       (adv),
    .load      (load_fire),
    .load_data (load_value),
    .ring      (ring),
    .wrap      (wrap)
  );

  assign phase     = PH_W'(johnson_phase(WIDTH, MAXW'(ring)));
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      target    <= '0;
      cycle_cnt <= '0;
      done      <= 1'b0;
`ifdef JOHNSON_LOAD_EN
      illegal   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // Wraps are counted in every state, including IDLE steps.
      if (wrap) cycle_cnt <= cycle_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (cmd_fire && cmd_op == OP_RUN) begin
            target    <= cmd_cycles;
            cycle_cnt <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          // Target reached and STOP on the same wrap collapse to one done.
          if (target_hit || (stop_fire && wrap)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (stop_fire) begin
            state <= HALT;
          end
        end
        HALT: begin
          if (wrap) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef JOHNSON_LOAD_EN
      if (load_fire && !load_ok) illegal <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

  localparam int W    = 5;
  localparam int CW   = 8;
  localparam int PW   = $clog2(2 * W);
  localparam int SEQ  = 2 * W;
  localparam int CMOD = 1 << CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] cmd_cycles = '0;
  logic [W-1:0]  ring;
  logic [PW-1:0] phase;
  logic [CW-1:0] cycle_cnt;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;
`ifdef JOHNSON_LOAD_EN
  logic          load_valid = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic          illegal;
`endif

  johnson_seq_ctrl #(.WIDTH(W), .CYC_W(CW), .PH_W(PW)) dut (
    .clk        (clk),
    .clear      (clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_cycles (cmd_cycles),
`ifdef JOHNSON_LOAD_EN
    .load_valid (load_valid),
    .load_data  (load_data),
    .illegal    (illegal),
`endif
    .ring       (ring),
    .phase      (phase),
    .cycle_cnt  (cycle_cnt),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ring pattern of sequence index p: first half fills from the MSB,
  // second half keeps the low 2W-p bits set.
  function automatic logic [W-1:0] ring_of(input int p);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      if (p <= W) r[b] = (b >= W - p);
      else        r[b] = (b < SEQ - p);
    end
    return r;
  endfunction

  function automatic int phase_of(input logic [W-1:0] d, output bit ok);
    ok = 0;
    for (int p = 0; p < SEQ; p++) begin
      if (ring_of(p) == d) begin
        ok = 1;
        return p;
      end
    end
    return 0;
  endfunction

  int m_ph, m_cnt, m_tgt, m_st;  // m_st: 0 idle, 1 running, 2 halting
  bit m_done, m_illegal;

  always @(posedge clk) begin
    bit acc, adv, wrap, ld, ldv;
    int lp;
    if (clear) begin
      m_ph = 0; m_cnt = 0; m_tgt = 0; m_st = 0; m_done = 0; m_illegal = 0;
    end else begin
      acc = cmd_valid && (m_st != 2);
      ld = 0; ldv = 0; lp = 0;
`ifdef JOHNSON_LOAD_EN
      if (load_valid && m_st == 0) begin
        ld = 1;
        lp = phase_of(load_data, ldv);
      end
`endif
      adv  = (m_st != 0) || (acc && cmd_op == 2'b10 && !ld);
      wrap = adv && (m_ph == SEQ - 1);
      m_done = 0;
      case (m_st)
        0: if (acc && cmd_op == 2'b01) begin
             m_tgt = int'(cmd_cycles); m_cnt = 0; m_st = 1;
           end
        1: if ((m_tgt != 0 && wrap && (m_cnt + 1) % CMOD == m_tgt) ||
               (acc && cmd_op == 2'b11 && wrap)) begin
             m_done = 1; m_st = 0;
           end else if (acc && cmd_op == 2'b11) begin
             m_st = 2;
           end
        default: if (wrap) begin m_done = 1; m_st = 0; end
      endcase
      if (wrap) m_cnt = (m_cnt + 1) % CMOD;
      if (ld) begin
        m_ph = ldv ? lp : 0;
        if (!ldv) m_illegal = 1;
      end else if (adv) begin
        m_ph = (m_ph + 1) % SEQ;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ring",      32'(ring),      32'(ring_of(m_ph)));
      chk("phase",     32'(phase),     32'(m_ph));
      chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
      chk("busy",      32'(busy),      32'(m_st != 0));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_st != 2));
      chk("done",      32'(done),      32'(m_done));
`ifdef JOHNSON_LOAD_EN
      chk("illegal",   32'(illegal),   32'(m_illegal));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [CW-1:0] cyc);
    cmd_valid = 1'b1; cmd_op = op; cmd_cycles = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_ring(input logic [W-1:0] r, input string nm);
    int n = 0;
    @(negedge clk);
    while (ring !== r && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (ring !== r) begin
      errors++;
      $display("FAIL %s timeout ring=%b exp=%b", nm, ring, r);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%b exp=0", busy);
    end
  endtask

  logic [W-1:0] step_exp [3];

  initial begin
    int n;
    step_exp[0] = 5'b10000; step_exp[1] = 5'b11000; step_exp[2] = 5'b11100;

    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_ring", 32'(ring), 0);
    chk("rst_cnt", 32'(cycle_cnt), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);

    // STEP x3 in IDLE
    for (int i = 0; i < 3; i++) begin
      send(2'b10, 0);
      @(negedge clk);
      chk("step_ring", 32'(ring), 32'(step_exp[i]));
      chk("step_phase", 32'(phase), i + 1);
      chk("step_busy", 32'(busy), 0);
      chk("step_done", 32'(done), 0);
    end

    // RUN 2 from ring 0
    pulse_clear();
    send(2'b01, 8'd2);
    wait_idle(n);
    chk("run2_busy_cycles", n, 20);
    chk("run2_done", 32'(done), 1);
    chk("run2_cnt", 32'(cycle_cnt), 2);
    chk("run2_ring", 32'(ring), 0);
    chk("run2_phase", 32'(phase), 0);
    chk("run2_ready", 32'(cmd_ready), 1);

    // free-run, STOP at 11100 -> HALT drains to zero
    send(2'b01, 8'd0);
    wait_ring(5'b11100, "stop_at_11100");
    send(2'b11, 0);
    @(negedge clk);
    chk("halt_ready", 32'(cmd_ready), 0);
    chk("halt_busy", 32'(busy), 1);
    wait_idle(n);
    chk("halt_done", 32'(done), 1);
    chk("halt_cnt", 32'(cycle_cnt), 1);
    chk("halt_ring", 32'(ring), 0);

    // STOP on the wrap cycle with target=1
    send(2'b01, 8'd1);
    wait_ring(5'b00001, "stop_on_wrap");
    send(2'b11, 0);
    @(negedge clk);
    chk("sw_done", 32'(done), 1);
    chk("sw_busy", 32'(busy), 0);
    chk("sw_cnt", 32'(cycle_cnt), 1);
    @(negedge clk);
    chk("sw_done_once", 32'(done), 0);

    // clear mid-run at phase 7 (ring 00111)
    send(2'b01, 8'd0);
    wait_ring(5'b00111, "phase7");
    chk("ph7", 32'(phase), 7);
    pulse_clear();
    @(negedge clk);
    chk("clr_ring", 32'(ring), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_cnt", 32'(cycle_cnt), 0);
    chk("clr_done", 32'(done), 0);

`ifdef JOHNSON_LOAD_EN
    load_valid = 1'b1; load_data = 5'b11100;
    @(posedge clk); #1 load_valid = 1'b0;
    @(negedge clk);
    chk("ld_phase", 32'(phase), 3);
    chk("ld_illegal", 32'(illegal), 0);
    load_valid = 1'b1; load_data = 5'b10100;
    @(posedge clk); #1 load_valid = 1'b0;
    @(negedge clk);
    chk("bad_ring", 32'(ring), 0);
    chk("bad_illegal", 32'(illegal), 1);
    repeat (3) @(negedge clk);
    chk("illegal_sticky", 32'(illegal), 1);
    pulse_clear();
    @(negedge clk);
    chk("illegal_clr", 32'(illegal), 0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      clear      = ($urandom_range(0, 79) == 0);
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_op     = 2'($urandom_range(0, 3));
      cmd_cycles = CW'($urandom_range(0, 3));
`ifdef JOHNSON_LOAD_EN
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = ($urandom_range(0, 1) == 0) ? ring_of($urandom_range(0, SEQ - 1))
                                               : W'($urandom);
`endif
    end
    @(posedge clk); #1;
    clear = 1'b0; cmd_valid = 1'b0;
`ifdef JOHNSON_LOAD_EN
    load_valid = 1'b0;
`endif
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
